ofm_writeback: RTL and testbench



---
 rtl/ofm_pkg.sv | 10 +
 rtl/ofm_writeback_if.sv | 12 +
 rtl/ofm_pix_fifo.sv | 30 +++
 rtl/ofm_writeback.sv | 90 +++++++++
 tb/tb_ofm_writeback.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ofm_pkg.sv
// ofm_pkg: shared constants, FSM state type and OFM address helper for the OFM writeback slice.
package ofm_pkg;
  localparam int unsigned LANES = 16;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORDS_PER_PIX = 4;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  function automatic logic [31:0] ofm_addr(input logic [31:0] pixel, tile, w, input int unsigned ntiles);
    return pixel * ntiles * WORDS_PER_PIX + tile * WORDS_PER_PIX + w;
  endfunction
endpackage

// File: rtl/ofm_writeback_if.sv
// ofm_writeback_if: OFM lane input and BRAM write port between the PE array, writeback and OFM buffer.
interface ofm_writeback_if
  import ofm_pkg::*;
#(parameter int ADDR_W = 20);
  logic [LANES-1:0] valid;
  logic [8*LANES-1:0] OFM_in;
  logic we_OFM;
  logic [ADDR_W-1:0] addr_OFM;
  logic [31:0] data_out_OFM;
  modport master (output valid, OFM_in, input we_OFM, addr_OFM, data_out_OFM);
  modport slave (input valid, OFM_in, output we_OFM, addr_OFM, data_out_OFM);
endinterface

// File: rtl/ofm_pix_fifo.sv
// ofm_pix_fifo: 2-deep pixel buffer; push while full is legal only together with a pop.
module ofm_pix_fifo #(parameter int W = 128) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2];
  logic wp, rp;
  logic [1:0] cnt;
  assign dout = mem[rp];
  assign full = cnt == 2'd2;
  assign empty = cnt == 2'd0;
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk)
    if (!reset) begin
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
    end else begin
      wp <= wp ^ push;
      rp <= rp ^ pop;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
endmodule

// File: rtl/ofm_writeback.sv
// ofm_writeback: captures 16-lane OFM pixels, packs them into 32-bit words and writes them to the OFM BRAM.
module ofm_writeback
  import ofm_pkg::*;
#(
  parameter int NUM_PIXELS = 3136,
  parameter int NUM_TILES = 2,
  parameter int ADDR_W = 20,
  parameter int BASE_ADDR = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  ofm_writeback_if.slave bus,
  output logic busy,
  output logic done,
  output logic overflow,
  output logic lane_err
);
  localparam int TOTAL = NUM_PIXELS * NUM_TILES;
  localparam int CW = $clog2(TOTAL + 1);
  localparam int PW = $clog2(NUM_PIXELS + 1);
  localparam int TW = $clog2(NUM_TILES + 1);
  state_t state;
  logic [CW-1:0] cap_cnt;
  logic [PW-1:0] pix;
  logic [TW-1:0] tile;
  logic [1:0] w;
  logic [8*LANES-1:0] head;
  logic [31:0] word;
  logic full, empty, push, pop, all_v, bad, last_pix;
  assign all_v = bus.valid == '1;
  assign bad = bus.valid != '0 && !all_v;
  // the head entry is freed on its 4th beat, which frees room for a capture in the same cycle
  assign pop = !empty && w == 2'd3;
  assign push = state == RUN && all_v && (!full || pop);
  assign last_pix = pix == PW'(NUM_PIXELS - 1);
  always_comb begin
    word = '0;
    for (int b = 0; b < BYTES_PER_WORD; b++) word[31-8*b -: 8] = head[{w, 2'(b), 3'b000} +: 8];
  end
  ofm_pix_fifo #(.W(8*LANES)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(bus.OFM_in),
    .dout(head), .full(full), .empty(empty)
  );
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      cap_cnt <= '0;
      pix <= '0;
      tile <= '0;
      w <= '0;
      bus.we_OFM <= 1'b0;
      bus.addr_OFM <= '0;
      bus.data_out_OFM <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      overflow <= 1'b0;
      lane_err <= 1'b0;
    end else begin
      bus.we_OFM <= !empty;
      done <= 1'b0;
      if (!empty) begin
        bus.addr_OFM <= ADDR_W'(32'(BASE_ADDR) + ofm_addr(32'(pix), 32'(tile), 32'(w), NUM_TILES));
        bus.data_out_OFM <= word;
        w <= w + 2'd1;
      end
      if (pop) begin
        pix <= last_pix ? '0 : pix + PW'(1);
        tile <= last_pix ? tile + TW'(1) : tile;
      end
      if (bad) lane_err <= 1'b1;
      if (state == RUN && all_v && !push) overflow <= 1'b1;
      if (state == IDLE && start) begin
        state <= RUN;
        busy <= 1'b1;
        cap_cnt <= '0;
        pix <= '0;
        tile <= '0;
        overflow <= 1'b0;
        lane_err <= bad;
      end else if (state == RUN && push) begin
        cap_cnt <= cap_cnt + CW'(1);
        if (cap_cnt == CW'(TOTAL - 1)) state <= DRAIN;
      end else if (state == DRAIN && empty) begin
        state <= IDLE;
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
endmodule

// File: tb/tb_ofm_writeback.sv
// tb_ofm_writeback: directed + randomized checks of ofm_writeback against a pixel-order reference model.
module tb_ofm_writeback;
  typedef struct packed {logic [19:0] addr; logic [31:0] data;} beat_t;
  localparam int NPB = 3136;
  localparam int TOTB = NPB * 2 * 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a = 1'b0, rst_b = 1'b0, start_a = 1'b0, start_b = 1'b0;
  logic busy_a, done_a, ovf_a, lerr_a, busy_b, done_b, ovf_b, lerr_b;
  int n_cmp = 0, n_err = 0;
  int beats_a = 0, beats_b = 0, dones_a = 0, dones_b = 0;
  beat_t qa[$], qb[$];
  beat_t ea, eb;
  logic seen_b [TOTB];
  ofm_writeback_if #(.ADDR_W(20)) ia();
  ofm_writeback_if #(.ADDR_W(20)) ib();
  ofm_writeback #(.NUM_PIXELS(4), .NUM_TILES(2), .ADDR_W(20), .BASE_ADDR(0)) dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .bus(ia.slave),
    .busy(busy_a), .done(done_a), .overflow(ovf_a), .lane_err(lerr_a)
  );
  ofm_writeback #(.NUM_PIXELS(NPB), .NUM_TILES(2), .ADDR_W(20), .BASE_ADDR(0)) dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .bus(ib.slave),
    .busy(busy_b), .done(done_b), .overflow(ovf_b), .lane_err(lerr_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] ref_addr(input int p, input int np, input int nt, input int w);
    return 20'(((p % np) * nt + p / np) * 4 + w);
  endfunction

  function automatic logic [31:0] ref_word(input logic [127:0] px, input int w);
    logic [31:0] r = '0;
    for (int b = 0; b < 4; b++) r = {r[23:0], px[8*(4*w+b) +: 8]};
    return r;
  endfunction

  function automatic logic [127:0] rand_px();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic add_a(input int p, input logic [127:0] px);
    for (int w = 0; w < 4; w++) qa.push_back('{ref_addr(p, 4, 2, w), ref_word(px, w)});
  endtask

  task automatic add_b(input int p, input logic [127:0] px);
    for (int w = 0; w < 4; w++) qb.push_back('{ref_addr(p, NPB, 2, w), ref_word(px, w)});
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (done_a) dones_a++;
    if (ia.we_OFM) begin
      beats_a++;
      if (qa.size() == 0) chk("a_unexpected_beat", {44'd0, ia.addr_OFM}, 64'hFFFFF);
      else begin
        ea = qa.pop_front();
        chk("a_beat", {ia.addr_OFM, ia.data_out_OFM}, ea);
      end
    end
  end

  always @(negedge clk) begin
    if (done_b) dones_b++;
    if (ib.we_OFM) begin
      beats_b++;
      if (qb.size() == 0) chk("b_unexpected_beat", {44'd0, ib.addr_OFM}, 64'hFFFFF);
      else begin
        eb = qb.pop_front();
        chk("b_beat", {ib.addr_OFM, ib.data_out_OFM}, eb);
      end
      if (ib.addr_OFM < 20'(TOTB)) begin
        chk("b_addr_once", 64'(seen_b[ib.addr_OFM]), 64'd0);
        seen_b[ib.addr_OFM] = 1'b1;
      end
    end
  end

  initial begin
    logic [127:0] px;
    logic [31:0] golden [4];
    logic bad_b;
    int nseen;
    golden = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
    for (int i = 0; i < TOTB; i++) seen_b[i] = 1'b0;
    ia.valid = '0; ia.OFM_in = '0; ib.valid = '0; ib.OFM_in = '0;
    tick(3);
    chk("a_rst_we", 64'(ia.we_OFM), 0);
    chk("a_rst_addr", 64'(ia.addr_OFM), 0);
    chk("a_rst_data", 64'(ia.data_out_OFM), 0);
    chk("a_rst_busy", 64'(busy_a), 0);
    chk("a_rst_done", 64'(done_a), 0);
    chk("a_rst_ovf", 64'(ovf_a), 0);
    chk("a_rst_lerr", 64'(lerr_a), 0);
    rst_a = 1'b1;
    tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("a_busy_run", 64'(busy_a), 1);
    // single pixel, lane k carries k+1
    for (int k = 0; k < 16; k++) px[8*k +: 8] = 8'(k + 1);
    ia.OFM_in = px; ia.valid = '1;
    add_a(0, px);
    tick();
    ia.valid = '0; ia.OFM_in = rand_px();
    chk("a_lat_idle", 64'(ia.we_OFM), 0);
    for (int w = 0; w < 4; w++) begin
      tick();
      chk("a_lat_we", 64'(ia.we_OFM), 1);
      chk("a_lat_addr", 64'(ia.addr_OFM), 64'(w));
      chk("a_lat_data", 64'(ia.data_out_OFM), 64'(golden[w]));
    end
    tick();
    chk("a_lat_end", 64'(ia.we_OFM), 0);
    // partial lane valid
    ia.valid = 16'h7FFF;
    tick();
    ia.valid = '0;
    chk("a_lerr_set", 64'(lerr_a), 1);
    tick(6);
    chk("a_lerr_nobeat", 64'(beats_a), 4);
    chk("a_ovf_clear", 64'(ovf_a), 0);
    // three back-to-back pixels: two fit, third overflows
    for (int i = 0; i < 3; i++) begin
      px = rand_px();
      ia.OFM_in = px; ia.valid = '1;
      if (i < 2) add_a(i + 1, px);
      tick();
    end
    ia.valid = '0;
    chk("a_ovf_set", 64'(ovf_a), 1);
    for (int i = 0; i < 7; i++) begin
      chk("a_gapless", 64'(ia.we_OFM), 1);
      tick();
    end
    chk("a_b2b_end", 64'(ia.we_OFM), 0);
    // remaining pixels cross the tile boundary and end the layer
    for (int p = 3; p < 8; p++) begin
      px = rand_px();
      ia.OFM_in = px; ia.valid = '1;
      add_a(p, px);
      tick();
      ia.valid = '0;
      tick(35);
    end
    chk("a_done_once", 64'(dones_a), 1);
    chk("a_busy_drop", 64'(busy_a), 0);
    chk("a_queue_empty", 64'(qa.size()), 0);
    ia.OFM_in = rand_px(); ia.valid = '1;
    tick();
    ia.valid = '0;
    tick(6);
    chk("a_idle_nowrite", 64'(beats_a), 32);
    chk("a_idle_lerr_kept", 64'(lerr_a), 1);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("a_start_lerr", 64'(lerr_a), 0);
    chk("a_start_ovf", 64'(ovf_a), 0);
    // reset after the second beat of a pixel
    px = rand_px();
    ia.OFM_in = px; ia.valid = '1;
    add_a(0, px);
    tick();
    ia.valid = '0;
    tick(2);
    rst_a = 1'b0;
    void'(qa.pop_back());
    void'(qa.pop_back());
    tick();
    rst_a = 1'b1;
    chk("a_mid_we", 64'(ia.we_OFM), 0);
    chk("a_mid_addr", 64'(ia.addr_OFM), 0);
    chk("a_mid_data", 64'(ia.data_out_OFM), 0);
    chk("a_mid_busy", 64'(busy_a), 0);
    chk("a_mid_lerr", 64'(lerr_a), 0);
    tick(6);
    chk("a_mid_nobeat", 64'(beats_a), 34);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    px = rand_px();
    ia.OFM_in = px; ia.valid = '1;
    add_a(0, px);
    tick();
    ia.valid = '0;
    tick(8);
    chk("a_restart_beats", 64'(beats_a), 38);
    chk("a_restart_queue", 64'(qa.size()), 0);
    // full default-size layer with random gaps and stray partial-valid cycles
    tick();
    rst_b = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("b_busy_run", 64'(busy_b), 1);
    bad_b = 1'b0;
    for (int p = 0; p < NPB * 2; p++) begin
      px = rand_px();
      ib.OFM_in = px; ib.valid = '1;
      add_b(p, px);
      tick();
      for (int g = 0; g < 3 + int'($urandom_range(0, 2)); g++) begin
        ib.OFM_in = rand_px();
        if ($urandom_range(0, 99) == 0) begin
          ib.valid = 16'($urandom_range(1, 65534));
          bad_b = 1'b1;
        end else ib.valid = '0;
        tick();
      end
      ib.valid = '0;
    end
    for (int i = 0; i < 40 && dones_b == 0; i++) tick();
    tick(5);
    nseen = 0;
    for (int i = 0; i < TOTB; i++) nseen += int'(seen_b[i]);
    chk("b_done_once", 64'(dones_b), 1);
    chk("b_beats", 64'(beats_b), 64'(TOTB));
    chk("b_all_addrs", 64'(nseen), 64'(TOTB));
    chk("b_busy_drop", 64'(busy_b), 0);
    chk("b_ovf", 64'(ovf_b), 0);
    chk("b_lerr", 64'(lerr_b), 64'(bad_b));
    chk("b_queue_empty", 64'(qb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
